// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: mode encodings, FSM states and a counter width helper.
package spi_pkg;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    // Bit counter width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for one asynchronous input, with a selectable reset value.
module spi_sync #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_gen.sv
// SPI slave for all four modes with multi-word frames; pins are synchronised into clk
// and one shift register serves both directions (sample shifts in, shift edge drives miso).
module spi_slave_gen
    import spi_pkg::*;
#(
    parameter int unsigned         DATA_W      = 8,
    parameter int unsigned         SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0]   TX_DEFAULT  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sck,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_underrun,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              abort
);

    localparam int unsigned CNT_W = cnt_width(DATA_W);

    logic sck_s;
    logic ss_s;
    logic mosi_s;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst_n(rst_n), .d(sck), .q(sck_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst_n(rst_n), .d(ss), .q(ss_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s)
    );

    state_e              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                sck_prev_q, sck_prev_d;
    logic                ss_prev_q, ss_prev_d;
    logic                miso_q, miso_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                tx_ready_q, tx_ready_d;
    logic                tx_underrun_q, tx_underrun_d;
    logic                rx_valid_q, rx_valid_d;
    logic                abort_q, abort_d;

    logic                sck_rise, sck_fall;
    logic                sample_e, shift_e;
    logic                last_bit;
    logic [DATA_W-1:0]   load_word;

    // Map the latched mode onto which sck edge samples mosi and which drives miso.
    always_comb begin
        sck_rise = !sck_prev_q && sck_s;
        sck_fall = sck_prev_q && !sck_s;
        sample_e = 1'b0;
        shift_e  = 1'b0;
        case (mode_q)
            MODE0: begin sample_e = sck_rise; shift_e = sck_fall; end
            MODE1: begin sample_e = sck_fall; shift_e = sck_rise; end
            MODE2: begin sample_e = sck_fall; shift_e = sck_rise; end
            MODE3: begin sample_e = sck_rise; shift_e = sck_fall; end
        endcase
        last_bit  = (bit_cnt_q == CNT_W'(DATA_W - 1));
        load_word = tx_valid ? tx_data : TX_DEFAULT;
    end

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        sck_prev_d    = sck_s;
        ss_prev_d     = ss_s;
        miso_d        = miso_q;
        rx_data_d     = rx_data_q;
        tx_ready_d    = 1'b0;
        tx_underrun_d = 1'b0;
        rx_valid_d    = 1'b0;
        abort_d       = 1'b0;

        case (state_q)
            IDLE: begin
                miso_d    = 1'b0;
                bit_cnt_d = '0;
                if (ss_prev_q && !ss_s) begin
                    state_d       = ACTIVE;
                    mode_d        = mode;
                    shift_d       = load_word;
                    tx_ready_d    = tx_valid;
                    tx_underrun_d = !tx_valid;
                    if (!mode[0]) begin
                        miso_d = load_word[DATA_W-1];
                    end
                end
            end
            ACTIVE: begin
                // A final sample takes priority over a coinciding ss release.
                if (sample_e && last_bit) begin
                    rx_data_d  = {shift_q[DATA_W-2:0], mosi_s};
                    rx_valid_d = 1'b1;
                    bit_cnt_d  = '0;
                    if (ss_s) begin
                        state_d = IDLE;
                        miso_d  = 1'b0;
                    end else begin
                        shift_d       = load_word;
                        tx_ready_d    = tx_valid;
                        tx_underrun_d = !tx_valid;
                        if (!mode_q[0]) begin
                            miso_d = load_word[DATA_W-1];
                        end
                    end
                end else if (ss_s) begin
                    state_d   = IDLE;
                    miso_d    = 1'b0;
                    bit_cnt_d = '0;
                    abort_d   = (bit_cnt_q != '0);
                end else if (sample_e) begin
                    shift_d   = {shift_q[DATA_W-2:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end else if (shift_e) begin
                    miso_d = shift_q[DATA_W-1];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            mode_q        <= 2'b00;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            sck_prev_q    <= 1'b0;
            ss_prev_q     <= 1'b1;
            miso_q        <= 1'b0;
            rx_data_q     <= '0;
            tx_ready_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            rx_valid_q    <= 1'b0;
            abort_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            sck_prev_q    <= sck_prev_d;
            ss_prev_q     <= ss_prev_d;
            miso_q        <= miso_d;
            rx_data_q     <= rx_data_d;
            tx_ready_q    <= tx_ready_d;
            tx_underrun_q <= tx_underrun_d;
            rx_valid_q    <= rx_valid_d;
            abort_q       <= abort_d;
        end
    end

    assign miso        = miso_q;
    assign rx_data     = rx_data_q;
    assign tx_ready    = tx_ready_q;
    assign tx_underrun = tx_underrun_q;
    assign rx_valid    = rx_valid_q;
    assign abort       = abort_q;

endmodule
